// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 arithmetic unit: opcodes, constants,
// FSM states and the exponent unbias helper.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [3:0] {
        GET,
        UNPACK,
        SPECIAL,
        ALIGN,
        ADD,
        MUL,
        DIV,
        NORMALISE,
        ROUND,
        PACK,
        PUT
    } state_e;

    function automatic logic signed [9:0] unbias(input logic [7:0] e);
        return 10'({2'b00, e}) - 10'(BIAS);
    endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Round-to-nearest-even on a 24-bit mantissa with G/R/S, registered on load,
// then packed to binary32 with overflow to infinity and underflow to zero.
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [26:0]       mant_in,
    output logic [31:0]       z
);

    logic              round_up;
    logic [24:0]       mant_sum;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [22:0]       r_frac;
    logic signed [9:0] biased;

    assign round_up = mant_in[2] & (mant_in[1] | mant_in[0] | mant_in[3]);
    assign mant_sum = {1'b0, mant_in[26:3]} + {24'b0, round_up};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_frac <= '0;
        end else if (load) begin
            r_sign <= sign;
            // rounding carry leaves 1.000..0, so renormalise by one
            if (mant_sum[24]) begin
                r_frac <= mant_sum[23:1];
                r_exp  <= exp_in + 10'sd1;
            end else begin
                r_frac <= mant_sum[22:0];
                r_exp  <= exp_in;
            end
        end
    end

    assign biased = r_exp + 10'(BIAS);

    always_comb begin
        z = {r_sign, biased[7:0], r_frac};
        if (biased > 10'sd254) begin
            z = POS_INF | {r_sign, 31'b0};
        end else if (biased < 10'sd1) begin
            z = {r_sign, 31'b0};
        end
    end

endmodule

// File: rtl/fpu.sv
// Free-running binary32 add/multiply/divide unit; operands latched in GET,
// result registered on output_z in PUT.
module fpu
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic [31:0] output_z
);

    state_e state, state_n;

    op_e               op_q;
    logic [31:0]       a_q, b_q;
    logic              sa, sb;
    logic signed [9:0] ea, eb;
    logic [23:0]       ma, mb;
    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    logic [26:0]       big_m, small_m;
    logic              eff_sub;
    logic [27:0]       nm;
    logic signed [9:0] ne;
    logic              zs;
    logic [25:0]       rem;
    logic [25:0]       quo;
    logic [4:0]        cnt;
    logic [31:0]       res;

    logic              spec_hit;
    logic [31:0]       spec_z;
    logic              zsign;

    logic              a_ge, big_s;
    logic [23:0]       big_ma, small_ma;
    logic signed [9:0] big_e, small_e;
    logic [9:0]        ediff;
    logic [4:0]        shamt;
    logic [53:0]       wide;
    logic [26:0]       align_m;

    logic [27:0]       add_res;
    logic              add_zero;
    logic [47:0]       prod;
    logic              div_ge;
    logic [25:0]       div_rem;
    logic [26:0]       q_next;

    logic              rp_load;
    logic [31:0]       rp_z;

    fpu_round_pack u_round_pack (
        .clk     (clk),
        .rst     (rst),
        .load    (rp_load),
        .sign    (zs),
        .exp_in  (ne),
        .mant_in (nm[26:0]),
        .z       (rp_z)
    );

    always_comb begin
        zsign    = sa ^ sb;
        spec_hit = 1'b1;
        spec_z   = '0;
        if (op_q == OP_RSV) begin
            spec_z = '0;
        end else if (a_nan || b_nan) begin
            spec_z = QNAN;
        end else begin
            case (op_q)
                OP_ADD: begin
                    if (a_inf && b_inf && (sa != sb)) spec_z = QNAN;
                    else if (a_inf)                   spec_z = a_q;
                    else if (b_inf)                   spec_z = b_q;
                    else if (a_zero && b_zero)        spec_z = {sa & sb, 31'b0};
                    else if (a_zero)                  spec_z = b_q;
                    else if (b_zero)                  spec_z = a_q;
                    else                              spec_hit = 1'b0;
                end
                OP_MUL: begin
                    if ((a_inf && b_zero) || (b_inf && a_zero)) spec_z = QNAN;
                    else if (a_inf || b_inf)                   spec_z = POS_INF | {zsign, 31'b0};
                    else if (a_zero || b_zero)                 spec_z = {zsign, 31'b0};
                    else                                       spec_hit = 1'b0;
                end
                default: begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) spec_z = QNAN;
                    else if (a_inf || b_zero)                  spec_z = POS_INF | {zsign, 31'b0};
                    else if (b_inf || a_zero)                  spec_z = {zsign, 31'b0};
                    else                                       spec_hit = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        a_ge     = (ea > eb) || ((ea == eb) && (ma >= mb));
        big_ma   = a_ge ? ma : mb;
        small_ma = a_ge ? mb : ma;
        big_e    = a_ge ? ea : eb;
        small_e  = a_ge ? eb : ea;
        big_s    = a_ge ? sa : sb;
        ediff    = big_e - small_e;
        shamt    = (ediff > 10'd27) ? 5'd27 : ediff[4:0];
        // bits shifted past the guard/round positions fold into the sticky bit
        wide     = {small_ma, 3'b000, 27'b0} >> shamt;
        align_m  = wide[53:27] | {26'b0, |wide[26:0]};
    end

    assign add_res  = eff_sub ? ({1'b0, big_m} - {1'b0, small_m})
                              : ({1'b0, big_m} + {1'b0, small_m});
    assign add_zero = (add_res == '0);
    assign prod     = 48'(ma) * 48'(mb);
    assign div_ge   = (rem >= {2'b00, mb});
    assign div_rem  = div_ge ? (rem - {2'b00, mb}) : rem;
    assign q_next   = {quo, div_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= GET;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        rp_load = 1'b0;
        case (state)
            GET:     state_n = UNPACK;
            UNPACK:  state_n = SPECIAL;
            SPECIAL: begin
                if (spec_hit)            state_n = PUT;
                else if (op_q == OP_ADD) state_n = ALIGN;
                else if (op_q == OP_MUL) state_n = MUL;
                else                     state_n = DIV;
            end
            ALIGN:     state_n = ADD;
            ADD:       state_n = (eff_sub && add_zero) ? PUT : NORMALISE;
            MUL:       state_n = NORMALISE;
            DIV:       if (cnt == 5'd26) state_n = NORMALISE;
            NORMALISE: if (!nm[27] && nm[26]) state_n = ROUND;
            ROUND: begin
                rp_load = 1'b1;
                state_n = PACK;
            end
            PACK:    state_n = PUT;
            PUT:     state_n = GET;
            default: state_n = GET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            ea       <= '0;
            eb       <= '0;
            ma       <= '0;
            mb       <= '0;
            a_nan    <= 1'b0;
            a_inf    <= 1'b0;
            a_zero   <= 1'b0;
            b_nan    <= 1'b0;
            b_inf    <= 1'b0;
            b_zero   <= 1'b0;
            big_m    <= '0;
            small_m  <= '0;
            eff_sub  <= 1'b0;
            nm       <= '0;
            ne       <= '0;
            zs       <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            res      <= '0;
            output_z <= '0;
        end else begin
            case (state)
                GET: begin
                    op_q <= op_e'(sel);
                    a_q  <= input_a;
                    b_q  <= input_b;
                end
                UNPACK: begin
                    sa     <= a_q[31];
                    sb     <= b_q[31];
                    ea     <= unbias(a_q[30:23]);
                    eb     <= unbias(b_q[30:23]);
                    ma     <= (a_q[30:23] != 8'h00) ? {1'b1, a_q[22:0]} : '0;
                    mb     <= (b_q[30:23] != 8'h00) ? {1'b1, b_q[22:0]} : '0;
                    a_nan  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
                    a_inf  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
                    a_zero <= (a_q[30:23] == 8'h00);
                    b_nan  <= (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
                    b_inf  <= (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
                    b_zero <= (b_q[30:23] == 8'h00);
                end
                SPECIAL: begin
                    res <= spec_z;
                    zs  <= zsign;
                    rem <= {2'b00, ma};
                    quo <= '0;
                    cnt <= '0;
                end
                ALIGN: begin
                    big_m   <= {big_ma, 3'b000};
                    small_m <= align_m;
                    ne      <= big_e;
                    zs      <= big_s;
                    eff_sub <= sa ^ sb;
                end
                ADD: begin
                    nm <= add_res;
                    if (add_zero) res <= '0;
                end
                MUL: begin
                    nm <= {prod[47:21], |prod[20:0]};
                    ne <= ea + eb;
                end
                DIV: begin
                    rem <= {div_rem[24:0], 1'b0};
                    quo <= q_next[25:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd26) begin
                        nm <= {1'b0, q_next[26:1], q_next[0] | (div_rem != '0)};
                        ne <= ea - eb;
                    end
                end
                NORMALISE: begin
                    if (nm[27]) begin
                        nm <= {1'b0, nm[27:2], nm[1] | nm[0]};
                        ne <= ne + 10'sd1;
                    end else if (!nm[26]) begin
                        nm <= {nm[26:0], 1'b0};
                        ne <= ne - 10'sd1;
                    end
                end
                PACK: res      <= rp_z;
                PUT:  output_z <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu.sv
// Scoreboard bench for fpu: stimulus pushes expected results, a monitor pops
// and compares them at the end of each hold window.
module tb_fpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [31:0] output_z;

    localparam int HOLD = 85;

    fpu dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .input_a  (input_a),
        .input_b  (input_b),
        .output_z (output_z)
    );

    always #10 clk = ~clk;

    logic [31:0] want_q[$];
    string       tag_q[$];
    int          checks   = 0;
    int          failures = 0;
    event        sample_ev;

    // binary32 normal -> real
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // nonzero real -> binary32, nearest-even, flush tiny, saturate to inf
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        int          biased;
        logic [52:0] f;
        logic [28:0] low;
        logic [24:0] k25;
        d   = $realtobits(r);
        e   = int'(d[62:52]) - 1023;
        f   = {1'b1, d[51:0]};
        low = f[28:0];
        k25 = {1'b0, f[52:29]};
        if ((low > 29'h1000_0000) || ((low == 29'h1000_0000) && f[29]))
            k25 = k25 + 25'd1;
        if (k25[24]) begin
            e   = e + 1;
            k25 = k25 >> 1;
        end
        biased = e + 127;
        if (biased > 254) return {d[63], 31'h7F80_0000};
        if (biased < 1)   return {d[63], 31'h0};
        return {d[63], 8'(biased), k25[22:0]};
    endfunction

    function automatic logic [31:0] ref_fpu(input logic [1:0] s, input logic [31:0] a,
                                            input logic [31:0] b);
        logic an, bn, ai, bi, az, bz, sz;
        real  ra, rb, r;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        sz = a[31] ^ b[31];
        if (s == 2'b11) return 32'h0;
        if (an || bn)   return 32'h7FC0_0000;
        ra = az ? 0.0 : (ai ? 1.0 : f2r(a));
        rb = bz ? 0.0 : (bi ? 1.0 : f2r(b));
        case (s)
            2'b00: begin
                if (ai && bi) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
                if (ai) return a;
                if (bi) return b;
                if (az && bz) return {a[31] & b[31], 31'h0};
                r = ra + rb;
            end
            2'b01: begin
                if ((ai && bz) || (bi && az)) return 32'h7FC0_0000;
                if (ai || bi) return {sz, 31'h7F80_0000};
                if (az || bz) return {sz, 31'h0};
                r = ra * rb;
            end
            default: begin
                if ((az && bz) || (ai && bi)) return 32'h7FC0_0000;
                if (ai || bz) return {sz, 31'h7F80_0000};
                if (bi || az) return {sz, 31'h0};
                r = ra / rb;
            end
        endcase
        if (r == 0.0) return 32'h0;
        return r2f(r);
    endfunction

    function automatic logic [31:0] rand_op();
        int unsigned k;
        logic [31:0] x;
        k = $urandom_range(0, 19);
        x = $urandom;
        case (k)
            0: x[30:0] = '0;
            1: x[30:23] = 8'h00;
            2: begin x[30:23] = 8'hFF; x[22:0] = '0; end
            3: begin x[30:23] = 8'hFF; x[22:0] = x[22:0] | 23'd1; end
            4: x[30:23] = 8'($urandom_range(240, 254));
            5: x[30:23] = 8'($urandom_range(1, 12));
            default: x[30:23] = 8'($urandom_range(100, 154));
        endcase
        return x;
    endfunction

    task automatic expect_val(input logic [31:0] want, input string tag);
        want_q.push_back(want);
        tag_q.push_back(tag);
    endtask

    task automatic apply(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input string tag);
        sel     = s;
        input_a = a;
        input_b = b;
        expect_val(want, $sformatf("%s sel=%0d a=%h b=%h", tag, s, a, b));
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        -> sample_ev;
    endtask

    initial begin
        logic [31:0] w;
        string       t;
        forever begin
            @(sample_ev);
            checks = checks + 1;
            if (want_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL scoreboard_empty: output_z=%h with no expected entry", output_z);
            end else begin
                w = want_q.pop_front();
                t = tag_q.pop_front();
                if (output_z !== w) begin
                    failures = failures + 1;
                    $display("FAIL %s: output_z=%h expected=%h", t, output_z, w);
                end
            end
        end
    end

    initial begin
        logic [1:0]  s;
        logic [31:0] a, b;
        int unsigned k;

        rst     = 1'b1;
        sel     = 2'b00;
        input_a = '0;
        input_b = '0;
        @(negedge clk);
        @(negedge clk);
        expect_val(32'h0, "reset_state");
        -> sample_ev;
        @(negedge clk);
        rst = 1'b0;

        apply(2'b00, 32'h41BB_EB85, 32'hC104_51EC, 32'h4173_851E, "add");
        apply(2'b01, 32'h40EC_CCCD, 32'h414E_6666, 32'h42BE_EB85, "mul");
        apply(2'b00, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "add_inf_minf");
        apply(2'b10, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "div_by_zero");
        apply(2'b01, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, "mul_zero_neg");
        apply(2'b11, 32'h40EC_CCCD, 32'h414E_6666, 32'h0000_0000, "reserved");
        apply(2'b00, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "add_cancel");
        apply(2'b01, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, "mul_overflow");
        apply(2'b01, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "mul_underflow");
        apply(2'b10, 32'h42FA_428F, 32'h414E_6666, 32'h411B_3333, "div");

        // FSM keeps re-running the division; reset lands while it is busy
        repeat (12) @(negedge clk);
        rst = 1'b1;
        expect_val(32'h0, "reset_mid_op");
        #2;
        -> sample_ev;
        sel     = 2'b00;
        input_a = 32'h3F80_0000;
        input_b = 32'h3F80_0000;
        @(negedge clk);
        rst = 1'b0;
        expect_val(32'h4000_0000, "add_after_reset_40clk");
        repeat (40) @(posedge clk);
        #1;
        -> sample_ev;

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            s = (k < 4) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
            a = rand_op();
            b = rand_op();
            if ((s == 2'b00) && ($urandom_range(0, 3) == 0))
                b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 15))};
            apply(s, a, b, ref_fpu(s, a, b), "rand");
        end

        @(negedge clk);
        checks = checks + 1;
        if (want_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", want_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
